// File: rtl/regfile_write_arbiter_if.sv
// Write-back bus between the two requesters (ALU, load unit) and the
// register-file write arbiter. The master side is the requester/consumer
// environment. The slave side is the arbiter itself.
interface regfile_write_arbiter_if #(
   parameter int DATA_W = 16
);

   // Port A: ALU write-back
   logic              a_valid;
   logic [2:0]        a_rd;
   logic [DATA_W-1:0] a_data;
   logic              a_ready;

   // Port B: memory load write-back
   logic              b_valid;
   logic [2:0]        b_rd;
   logic [DATA_W-1:0] b_data;
   logic              b_ready;

   // Pipeline flush: discards both holding entries
   logic              flush;

   // Register-file write port: one-hot strobes plus shared data
   logic              regwrite_r1;
   logic              regwrite_r2;
   logic              regwrite_r3;
   logic              regwrite_r4;
   logic              regwrite_r5;
   logic              regwrite_r6;
   logic              regwrite_r7;
   logic [DATA_W-1:0] writeData;

   // Registers with a held, not-yet-issued write (bit i-1 <-> r_i)
   logic [6:0]        pending_mask;

   modport master (
      output a_valid, a_rd, a_data,
      input  a_ready,
      output b_valid, b_rd, b_data,
      input  b_ready,
      output flush,
      input  regwrite_r1, regwrite_r2, regwrite_r3, regwrite_r4,
      input  regwrite_r5, regwrite_r6, regwrite_r7,
      input  writeData,
      input  pending_mask
   );

   modport slave (
      input  a_valid, a_rd, a_data,
      output a_ready,
      input  b_valid, b_rd, b_data,
      output b_ready,
      input  flush,
      output regwrite_r1, regwrite_r2, regwrite_r3, regwrite_r4,
      output regwrite_r5, regwrite_r6, regwrite_r7,
      output writeData,
      output pending_mask
   );

endinterface

// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter. ALU (port A) and load (port B)
// write-backs each land in a one-entry holder. The older held write issues
// first as a registered one-hot strobe plus writeData. Two writes to the
// same register therefore always retire in acceptance order. A registered
// mask of held destinations is published for decode hazard detection.
module regfile_write_arbiter #(
   parameter int DATA_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   regfile_write_arbiter_if.slave   bus
);

   typedef struct packed {
      logic              full;
      logic [2:0]        rd;
      logic [DATA_W-1:0] data;
   } holder_t;

   // One-hot decode of a destination register. r0 maps to no bit.
   function automatic logic [6:0] rd_onehot(input logic [2:0] rd);
      logic [6:0] oh;
      oh = '0;
      for (int i = 1; i < 8; i++) begin
         if (rd == 3'(i)) oh[i-1] = 1'b1;
      end
      return oh;
   endfunction

   holder_t           a_q, a_d;
   holder_t           b_q, b_d;
   logic              b_older_q, b_older_d;   // 1: holder B was loaded before A
   logic [6:0]        pend_q, pend_d;
   logic [6:0]        strobe_q, strobe_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   logic              grant_a, grant_b;
   logic              a_ready, b_ready;
   logic              load_a, load_b;

   // Oldest-first grant on holder state. A flush suppresses any grant, so no strobe follows it.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      grant_a = 1'b0;
      grant_b = 1'b0;
      if (!bus.flush) begin
         if (a_q.full && b_q.full) begin
            if (b_older_q) grant_b = 1'b1;
            else           grant_a = 1'b1;
         end else if (a_q.full) begin
            grant_a = 1'b1;
         end else if (b_q.full) begin
            grant_b = 1'b1;
         end
      end
   end

   // A holder can accept when empty or draining this edge. Accepts are blocked during reset and flush.
   assign a_ready = ~rst & ~bus.flush & (~a_q.full | grant_a);
   assign b_ready = ~rst & ~bus.flush & (~b_q.full | grant_b);

   // Writes to r0 are consumed by the handshake but never stored.
   assign load_a = bus.a_valid & a_ready & (bus.a_rd != 3'd0);
   assign load_b = bus.b_valid & b_ready & (bus.b_rd != 3'd0);

   // Next holder, age and pending-mask state.
   always_comb begin
      a_d       = a_q;
      b_d       = b_q;
      b_older_d = b_older_q;

      if (bus.flush) begin
         a_d.full  = 1'b0;
         b_d.full  = 1'b0;
         b_older_d = 1'b0;
      end else begin
         if (load_a) begin
            a_d.full = 1'b1;
            a_d.rd   = bus.a_rd;
            a_d.data = bus.a_data;
         end else if (grant_a) begin
            a_d.full = 1'b0;
         end

         if (load_b) begin
            b_d.full = 1'b1;
            b_d.rd   = bus.b_rd;
            b_d.data = bus.b_data;
         end else if (grant_b) begin
            b_d.full = 1'b0;
         end

         // The entry that stays put is older than a freshly loaded one.
         // Simultaneous loads leave A older.
         if (load_a && load_b)
            b_older_d = 1'b0;
         else if (load_a && b_q.full && !grant_b)
            b_older_d = 1'b1;
         else if (load_b && a_q.full && !grant_a)
            b_older_d = 1'b0;
      end

      pend_d = (a_d.full ? rd_onehot(a_d.rd) : 7'd0) |
               (b_d.full ? rd_onehot(b_d.rd) : 7'd0);
   end

   // Issue: the granted holder becomes a one-cycle strobe. writeData holds between issues.
   always_comb begin
      strobe_d = '0;
      wdata_d  = wdata_q;
      if (grant_a) begin
         strobe_d = rd_onehot(a_q.rd);
         wdata_d  = a_q.data;
      end else if (grant_b) begin
         strobe_d = rd_onehot(b_q.rd);
         wdata_d  = b_q.data;
      end
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: holder data is reset along with the full flags. It is only a few flops, and it keeps writeData and the holders deterministic after reset.
         a_q       <= '0;
         b_q       <= '0;
         b_older_q <= 1'b0;
         pend_q    <= '0;
         strobe_q  <= '0;
         wdata_q   <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
         a_q       <= a_d;
         b_q       <= b_d;
         b_older_q <= b_older_d;
         pend_q    <= pend_d;
         strobe_q  <= strobe_d;
         wdata_q   <= wdata_d;
      end
   end

   assign bus.a_ready      = a_ready;
   assign bus.b_ready      = b_ready;
   assign bus.regwrite_r1  = strobe_q[0];
   assign bus.regwrite_r2  = strobe_q[1];
   assign bus.regwrite_r3  = strobe_q[2];
   assign bus.regwrite_r4  = strobe_q[3];
   assign bus.regwrite_r5  = strobe_q[4];
   assign bus.regwrite_r6  = strobe_q[5];
   assign bus.regwrite_r7  = strobe_q[6];
   assign bus.writeData    = wdata_q;
   assign bus.pending_mask = pend_q;

   // More than one write strobe in a cycle would corrupt the register file.
   strobe_onehot_a : assert property (@(posedge clk) disable iff (rst) $onehot0(strobe_q));

endmodule
